// File: rtl/conv_bram_sr_fast_ctrl_pkg.sv
// Shared definitions for the fast shift-register conv blocks (control and datapath).
// Contents:
//   state_e / ST_*        control FSM state encoding (IDLE, SWEEP, DRAIN, FIN)
//   calc_result_w/_h      output feature-map dimensions
//   calc_sweep_w          number of image columns read per output row
//   calc_bank_addr_width  address width of one source-image bank
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SWEEP = SWEEP;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_FIN   = FIN;

  function automatic int calc_result_w(int img_w, int filter_l, int stride_w);
    return (img_w - filter_l) / stride_w + 1;
  endfunction

  function automatic int calc_result_h(int img_h, int filter_l, int stride_h);
    return (img_h - filter_l) / stride_h + 1;
  endfunction

  function automatic int calc_sweep_w(int result_w, int stride_w, int filter_l);
    return (result_w - 1) * stride_w + filter_l;
  endfunction

  function automatic int calc_bank_addr_width(int img_w, int img_h, int filter_l);
    return $clog2(((img_h + filter_l - 1) / filter_l) * img_w);
  endfunction

endpackage

// File: rtl/conv_bram_sr_fast_ctrl_if.sv
// Control-to-memory/datapath bundle of the fast shift-register conv pipeline.
// Signals:
//   img_rdaddr             per-bank read address, bank b at [b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH]
//   img_rden               bank read enable
//   dpath_wren             shift-register / multiplier valid, aligned to read data
//   dpath_sum_en           mirrors dpath_wren
//   dpath_rotation_offset  bank rotation of the current row, aligned to read data
//   dpath_result_wraddr    result RAM address, aligned to read data
//   last_val               datapath reports that the final result write happened
// Handshake: img_rden and dpath_wren are valid-only strobes; there is no ready
// and no backpressure, so a strobe high in a cycle is consumed in that cycle.
// last_val is an event from the datapath, only honoured while the control waits
// in its drain state.
interface conv_bram_sr_fast_ctrl_if #(
  parameter int FILTER_L              = 3,
  parameter int BANK_ADDR_WIDTH       = 4,
  parameter int FILTER_L_ADDR_WIDTH   = 2,
  parameter int RESULT_RAM_ADDR_WIDTH = 4
);
  logic [FILTER_L*BANK_ADDR_WIDTH-1:0] img_rdaddr;
  logic                                img_rden;
  logic                                dpath_wren;
  logic                                dpath_sum_en;
  logic [FILTER_L_ADDR_WIDTH-1:0]      dpath_rotation_offset;
  logic [RESULT_RAM_ADDR_WIDTH-1:0]    dpath_result_wraddr;
  logic                                last_val;

  modport master (
    output img_rdaddr, img_rden, dpath_wren, dpath_sum_en,
           dpath_rotation_offset, dpath_result_wraddr,
    input  last_val
  );

  modport slave (
    input  img_rdaddr, img_rden, dpath_wren, dpath_sum_en,
           dpath_rotation_offset, dpath_result_wraddr,
    output last_val
  );
endinterface

// File: rtl/conv_bram_sr_fast_ctrl_align_pipe.sv
// Fixed-depth register pipeline that delays the issued {valid, offset, wraddr}
// tuple so it lines up with the BRAM read data.
// Ports: clk, reset (async, active high), d (issued tuple), q (delayed tuple).
module conv_ctrl_align_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] stage [DEPTH];

  // Reset clears every stage so no stale valid leaks out after an aborted pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];
endmodule

// File: rtl/conv_bram_sr_fast_ctrl.sv
// Control stage of the fast shift-register conv: sweeps the banked image BRAMs
// column by column for every output row, issues per-bank read addresses and
// drives the datapath strobes delayed by RAM_LATENCY.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   start            one-cycle pulse starting a full-image pass (IDLE only)
//   busy             high in SWEEP, DRAIN and FIN
//   done             one-cycle pulse in FIN
//   state_dbg        current FSM state (conv_pkg::ST_*)
//   dp               master side of conv_bram_sr_fast_ctrl_if
module conv_bram_sr_fast_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W       = 16,
  parameter int IMG_H       = 16,
  parameter int FILTER_L    = 3,
  parameter int STRIDE_W    = 1,
  parameter int STRIDE_H    = 1,
  parameter int RAM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg,
  conv_bram_sr_fast_ctrl_if.master dp
);
  localparam int RESULT_W = calc_result_w(IMG_W, FILTER_L, STRIDE_W);
  localparam int RESULT_H = calc_result_h(IMG_H, FILTER_L, STRIDE_H);
  localparam int SWEEP_W  = calc_sweep_w(RESULT_W, STRIDE_W, FILTER_L);
  localparam int BAW      = calc_bank_addr_width(IMG_W, IMG_H, FILTER_L);
  localparam int FLAW     = $clog2(FILTER_L);
  localparam int RRAW     = $clog2(RESULT_W * RESULT_H);
  localparam int COL_W    = $clog2(SWEEP_W + 1);
  localparam int ROW_W    = $clog2(RESULT_H + 1);
  localparam int PH_W     = $clog2(STRIDE_W + 1);
  localparam int OC_W     = $clog2(RESULT_W + 1);
  localparam int PIPE_W   = 1 + FLAW + RRAW;

  logic [1:0]       state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PH_W-1:0]  phase;
  logic [OC_W-1:0]  out_col;
  logic [FLAW-1:0]  offset;
  logic [BAW-1:0]   grp_addr;
  logic [RRAW-1:0]  res_row_base;

  logic             rden;
  logic             col_last;
  logic             past_warmup;
  logic             col_valid;
  logic [FLAW:0]    off_sum;
  logic             off_wrap;
  logic [RRAW-1:0]  wraddr;
  logic [PIPE_W-1:0] pipe_q;

  assign rden        = (state == ST_SWEEP);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_FIN);
  assign state_dbg   = state;
  assign col_last    = (col == COL_W'(SWEEP_W - 1));
  assign past_warmup = (col >= COL_W'(FILTER_L - 1));
  // phase tracks (col-(FILTER_L-1)) mod STRIDE_W without a divider.
  assign col_valid   = past_warmup && (phase == '0);
  // One extra bit: offset < FILTER_L and STRIDE_H <= FILTER_L keep the sum below 2*FILTER_L.
  assign off_sum     = {1'b0, offset} + (FLAW + 1)'(STRIDE_H);
  assign off_wrap    = (off_sum >= (FLAW + 1)'(FILTER_L));
  // Warm-up and stride-skip columns carry the next valid output's address; the
  // valid column overwrites it later in the same row.
  assign wraddr      = res_row_base + RRAW'(out_col);

  // Banks below the rotation offset already hold the next row group.
  always_comb begin
    dp.img_rdaddr = '0;
    for (int b = 0; b < FILTER_L; b++) begin
      dp.img_rdaddr[b*BAW +: BAW] = grp_addr + ((b < int'(offset)) ? BAW'(IMG_W) : BAW'(0))
                                    + BAW'(col);
    end
  end

  assign dp.img_rden = rden;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      col          <= '0;
      row          <= '0;
      phase        <= '0;
      out_col      <= '0;
      offset       <= '0;
      grp_addr     <= '0;
      res_row_base <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_SWEEP;
            col          <= '0;
            row          <= '0;
            phase        <= '0;
            out_col      <= '0;
            offset       <= '0;
            grp_addr     <= '0;
            res_row_base <= '0;
          end
        end
        ST_SWEEP: begin
          if (col_last) begin
            col     <= '0;
            phase   <= '0;
            out_col <= '0;
            if (row == ROW_W'(RESULT_H - 1)) begin
              state <= ST_DRAIN;
            end else begin
              row          <= row + 1'b1;
              offset       <= FLAW'(off_wrap ? off_sum - (FLAW + 1)'(FILTER_L) : off_sum);
              res_row_base <= res_row_base + RRAW'(RESULT_W);
              if (off_wrap) grp_addr <= grp_addr + BAW'(IMG_W);
            end
          end else begin
            col <= col + 1'b1;
            if (past_warmup) phase <= (phase == PH_W'(STRIDE_W - 1)) ? '0 : phase + 1'b1;
            if (col_valid) out_col <= out_col + 1'b1;
          end
        end
        ST_DRAIN: if (dp.last_val) state <= ST_FIN;
        ST_FIN:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  conv_ctrl_align_pipe #(
    .DEPTH(RAM_LATENCY),
    .W    (PIPE_W)
  ) u_align (
    .clk  (clk),
    .reset(reset),
    .d    ({rden, offset, wraddr}),
    .q    (pipe_q)
  );

  assign dp.dpath_wren            = pipe_q[PIPE_W-1];
  assign dp.dpath_sum_en          = pipe_q[PIPE_W-1];
  assign dp.dpath_rotation_offset = pipe_q[RRAW +: FLAW];
  assign dp.dpath_result_wraddr   = pipe_q[RRAW-1:0];
endmodule

// File: doc/conv_bram_sr_fast_ctrl.md
Name: conv_bram_sr_fast_ctrl

Overview:
- Control stage directly upstream of the fast shift-register conv datapath (conv_bram_sr_fast_dpath).
- Sweeps the banked source-image BRAMs column by column for each output row, and issues the per-bank read addresses.
- Drives the datapath with its shift enable, rotation offset and result write address, each aligned to BRAM read latency.
- Receives last_val back from the datapath to detect completion.
- Image layout: each channel is split over FILTER_L banks; image row h lives in bank (h mod FILTER_L) at address (h / FILTER_L)*IMG_W + w.

Parameters:
- IMG_W, 16, image width.
- IMG_H, 16, image height.
- FILTER_L, 3, square filter side.
- STRIDE_W, 1, horizontal stride; legal range is 1..FILTER_L.
- STRIDE_H, 1, vertical stride; legal range is 1..FILTER_L.
- RAM_LATENCY, 1, BRAM read latency in cycles; legal range is 1..4.
- Derived, not set manually:
  - RESULT_W = (IMG_W-FILTER_L)/STRIDE_W+1 and RESULT_H = (IMG_H-FILTER_L)/STRIDE_H+1.
  - SWEEP_W = (RESULT_W-1)*STRIDE_W+FILTER_L, the number of columns read per output row.
  - BANK_ADDR_WIDTH = $clog2(((IMG_H+FILTER_L-1)/FILTER_L)*IMG_W).
  - FILTER_L_ADDR_WIDTH = $clog2(FILTER_L) and RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W*RESULT_H).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a full-image pass.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the final result has been written.
- img_rdaddr  out  FILTER_L*BANK_ADDR_WIDTH  read address per bank; bank b occupies bits [b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH]; shared by all channels.
- img_rden  out  1  bank read enable.
- dpath_wren  out  1  shift-register and multiplier valid, aligned to read data.
- dpath_sum_en  out  1  always equal to dpath_wren (reserved).
- dpath_rotation_offset  out  FILTER_L_ADDR_WIDTH  bank rotation for the current row, aligned to read data.
- dpath_result_wraddr  out  RESULT_RAM_ADDR_WIDTH  result address, aligned to read data.
- last_val  in  1  from the datapath: final result write has occurred.

Behaviour:
- Reset value of every output is 0; the FSM enters IDLE. An asynchronous reset mid-pass aborts the pass and clears the alignment pipeline, so no stale dpath_wren is emitted.
- FSM states: IDLE, SWEEP, DRAIN, FIN.
  - IDLE: a start pulse moves to SWEEP and clears counters. start is ignored in every other state.
  - SWEEP, each cycle:
    - img_rden=1, and a column w=col is issued.
    - col runs 0..SWEEP_W-1, then wraps to 0 and row increments.
    - After row RESULT_H-1, column SWEEP_W-1, go to DRAIN.
  - DRAIN: img_rden=0; wait for last_val, then go to FIN.
  - FIN: done=1 for one cycle, then IDLE. busy=1 in SWEEP, DRAIN and FIN.
- Per-row state is incremental; there is no divider or modulo hardware.
  - Registers: offset = (row*STRIDE_H) mod FILTER_L, grp_addr = ((row*STRIDE_H)/FILTER_L)*IMG_W, res_row_base = row*RESULT_W.
  - On row advance: offset += STRIDE_H. If the result is >= FILTER_L, subtract FILTER_L and add IMG_W to grp_addr. res_row_base += RESULT_W.
- Bank address: img_rdaddr[b] = grp_addr + (b < offset ? IMG_W : 0) + col.
- Valid column: col >= FILTER_L-1 and (col-(FILTER_L-1)) mod STRIDE_W == 0. Track this with a phase counter that wraps at STRIDE_W.
  - out_col increments after each valid column and is reset to 0 each row.
- Write address: wraddr = res_row_base + out_col.
  - Non-valid (warm-up or stride-skip) columns also pulse dpath_wren, so the shift register advances.
  - Their wraddr equals the next valid output's address; that address is overwritten in order later in the same row. Only in-order writes are allowed.
- Latency: dpath_wren, dpath_rotation_offset and dpath_result_wraddr equal img_rden, offset and wraddr delayed by exactly RAM_LATENCY cycles (shift pipeline).
- The number of dpath_wren pulses per pass equals RESULT_H*SWEEP_W.
- last_val is only acted on in DRAIN. If it arrives together with a start, start is ignored.

Decomposition:
- Shared package conv_pkg holds:
  - the state enum (IDLE/SWEEP/DRAIN/FIN);
  - constant functions for RESULT_W, RESULT_H, SWEEP_W and BANK_ADDR_WIDTH, shared with the datapath.
- One sub-module: conv_ctrl_align_pipe, a parameterised RAM_LATENCY-deep register pipeline with asynchronous reset, carrying {valid, offset, wraddr}.

Test Plan:
- 5x5 image, L=3, strides 1, latency 1, start → 15 dpath_wren pulses.
  - Row 0 addresses: b0=b1=b2=w for w=0..4, offset 0.
  - wraddr sequence 0,0,0,1,2; busy high until done.
- Same configuration, row 1 → offset 1; bank0 addr 5+w, bank1 w, bank2 w; wraddr 3,3,3,4,5.
- IMG 7x5, L=3, STRIDE_W=2 → RESULT_W=3, SWEEP_W=7.
  - Row 0 wraddr 0,0,0,1,1,2,2; valid columns 2,4,6.
- STRIDE_H=3, IMG_H=9, L=3 → offset stays 0 and grp_addr steps 0, IMG_W, 2*IMG_W.
- RAM_LATENCY=3 → the first dpath_wren appears 3 cycles after the first img_rden; drive last_val 5 cycles after the last issue → done is one pulse, one cycle after last_val.
- Assert reset during SWEEP row 1 → all outputs are 0 immediately; a new start restarts at row 0, col 0; a start pulse during DRAIN is ignored.
